round_sat_pipe: RTL and testbench

Multi-channel, pipelined fixed-point width reducer that succeeds the single-channel unsigned round-half-to-even rounder. It drops `IN_W-OUT_W` fractional LSBs from each lane using a per-beat selectable rounding mode, handles signed or unsigned data, clamps to the output range, and reports saturation per lane. It sits between wide datapath stages (filters, MAC accumulators) and narrower consumers, with a valid/ready stream interface on both sides.

---
 rtl/round_sat_pipe.sv | 131 +++++++++++++
 tb/tb_round_sat_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sat_pipe.sv
// Two-stage multi-lane width reducer: stage 1 rounds (truncate / half-up / half-even),
// stage 2 clamps to the output range. Optional ROUND_SAT_STATS_EN adds the sat_count port.
module round_sat_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned SIGNED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*IN_W-1:0]  din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] dout,
  output logic [LANES-1:0]       sat
`ifdef ROUND_SAT_STATS_EN
  ,
  output logic [15:0]            sat_count
`endif
);

  localparam int F  = int'(IN_W) - int'(OUT_W);
  localparam int SW = int'(OUT_W) + 1;
  localparam bit Sgn = (SIGNED != 0);
  localparam logic [OUT_W-1:0] SMin = OUT_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] SMax = ~SMin;

  logic                   s1_valid, s2_valid;
  logic                   s1_load, s2_load;
  logic [LANES*SW-1:0]    s1_d, s1_q;
  logic [LANES*OUT_W-1:0] dout_d;
  logic [LANES-1:0]       sat_d;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    logic [IN_W-1:0]  x;
    logic [SW-1:0]    s_rnd;
    logic [SW-1:0]    s2_in;
    logic [OUT_W-1:0] lane_out;
    logic             lane_sat;

    assign x = din[k*IN_W +: IN_W];

    if (F > 0) begin : g_rnd
      localparam logic [F-1:0] Half = F'(1) << (F - 1);
      logic [OUT_W-1:0] ip;
      logic [F-1:0]     r;
      logic             ext;
      logic             inc;

      assign ip  = x[IN_W-1:F];
      assign r   = x[F-1:0];
      assign ext = Sgn ? ip[OUT_W-1] : 1'b0;

      always_comb begin
        inc = 1'b0;
        case (in_mode)
          2'd0:    inc = 1'b0;
          2'd1:    inc = (r >= Half);
          default: inc = (r > Half) || ((r == Half) && ip[0]);
        endcase
      end

      // One extra MSB keeps the +1 carry so stage 2 can see the overflow.
      assign s_rnd = {ext, ip} + SW'(inc);
    end else begin : g_ext
      logic unused_mode;
      assign unused_mode = ^in_mode;
      assign s_rnd = {{(SW - int'(IN_W)){Sgn & x[IN_W-1]}}, x};
    end

    assign s1_d[k*SW +: SW] = s_rnd;
    assign s2_in = s1_q[k*SW +: SW];

    always_comb begin
      lane_out = s2_in[OUT_W-1:0];
      lane_sat = 1'b0;
      if (Sgn) begin
        // Top two bits disagree only when the value left the OUT_W signed range.
        if (s2_in[OUT_W] != s2_in[OUT_W-1]) begin
          lane_sat = 1'b1;
          lane_out = s2_in[OUT_W] ? SMin : SMax;
        end
      end else if (s2_in[OUT_W]) begin
        lane_sat = 1'b1;
        lane_out = '1;
      end
    end

    assign dout_d[k*OUT_W +: OUT_W] = lane_out;
    assign sat_d[k]                 = lane_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      dout     <= '0;
      sat      <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (in_valid && s1_load) s1_q <= s1_d;
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          dout <= dout_d;
          sat  <= sat_d;
        end
      end
    end
  end

`ifdef ROUND_SAT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|sat) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: three configurations share one handshake and
// are checked against an arithmetic rounding/clamping model.
module tb_round_sat_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic [31:0] din;
  logic        out_ready;
  logic [7:0]  din_w;

  logic        rdy_u, rdy_s, rdy_w;
  logic        ov_u, ov_s, ov_w;
  logic [15:0] dout_u, dout_s;
  logic [11:0] dout_w;
  logic [3:0]  sat_u, sat_s;
  logic [1:0]  sat_w;
`ifdef ROUND_SAT_STATS_EN
  logic [15:0] cnt_u, cnt_s, cnt_w;
  int          ecnt_u, ecnt_s, ecnt_w;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t q_u[$], q_s[$], q_w[$];
  int   occ;
  int   bp_sel;
  int   bp_ph;

  assign din_w = din[7:0];

  always #5 clk = ~clk;

  round_sat_pipe #(.IN_W(8), .OUT_W(4), .LANES(4), .SIGNED(0)) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .in_mode(in_mode),
    .din(din), .out_valid(ov_u), .out_ready(out_ready), .dout(dout_u), .sat(sat_u)
`ifdef ROUND_SAT_STATS_EN
    , .sat_count(cnt_u)
`endif
  );

  round_sat_pipe #(.IN_W(8), .OUT_W(4), .LANES(4), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_mode(in_mode),
    .din(din), .out_valid(ov_s), .out_ready(out_ready), .dout(dout_s), .sat(sat_s)
`ifdef ROUND_SAT_STATS_EN
    , .sat_count(cnt_s)
`endif
  );

  round_sat_pipe #(.IN_W(4), .OUT_W(6), .LANES(2), .SIGNED(1)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_mode(in_mode),
    .din(din_w), .out_valid(ov_w), .out_ready(out_ready), .dout(dout_w), .sat(sat_w)
`ifdef ROUND_SAT_STATS_EN
    , .sat_count(cnt_w)
`endif
  );

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: exact value, floor-divide by 2^F, apply the mode's tie rule, clamp.
  function automatic int model_lane(input int raw, input int in_w, input int out_w,
                                    input bit sgn, input int mode, output bit sat_o);
    int v, f, q, rem, half, lo, hi;
    v = (sgn && raw[in_w-1]) ? raw - (1 << in_w) : raw;
    f = in_w - out_w;
    q = v;
    if (f > 0) begin
      q    = v >>> f;
      rem  = v - q * (1 << f);
      half = 1 << (f - 1);
      if (mode == 1 && rem >= half) q = q + 1;
      else if (mode >= 2 && (rem > half || (rem == half && (q & 1) != 0))) q = q + 1;
    end
    lo = sgn ? -(1 << (out_w - 1)) : 0;
    hi = sgn ? (1 << (out_w - 1)) - 1 : (1 << out_w) - 1;
    sat_o = 1'b0;
    if (q > hi) begin
      q = hi;
      sat_o = 1'b1;
    end else if (q < lo) begin
      q = lo;
      sat_o = 1'b1;
    end
    return q & ((1 << out_w) - 1);
  endfunction

  function automatic exp_t model_beat(input logic [31:0] d, input int in_w, input int out_w,
                                      input int lanes, input bit sgn, input int mode);
    exp_t e;
    int   raw, v;
    bit   sb;
    e = '0;
    for (int l = 0; l < lanes; l++) begin
      raw = int'((d >> (l * in_w)) & ((32'd1 << in_w) - 32'd1));
      v   = model_lane(raw, in_w, out_w, sgn, mode, sb);
      e.d = e.d | 16'(v << (l * out_w));
      e.s[l] = sb;
    end
    return e;
  endfunction

  task automatic push_expected(input logic [31:0] d, input logic [1:0] m);
    q_u.push_back(model_beat(d, 8, 4, 4, 1'b0, int'(m)));
    q_s.push_back(model_beat(d, 8, 4, 4, 1'b1, int'(m)));
    q_w.push_back(model_beat({24'd0, d[7:0]}, 4, 6, 2, 1'b1, int'(m)));
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [31:0] d, input logic [1:0] m);
    int tries = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    din      = d;
    in_mode  = m;
    while (!done) begin
      @(negedge clk);
      if (rdy_u) begin
        push_expected(d, m);
        done = 1'b1;
      end else if (++tries > 50) begin
        check("send_timeout", 1'b0, 32'(tries), 32'd50);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = $urandom;
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic direct(input logic [31:0] d, input logic [1:0] m, input logic [2:0] en,
                        input logic [15:0] eu, input logic [3:0] su,
                        input logic [15:0] es, input logic [3:0] ss,
                        input logic [11:0] ew, input logic [1:0] sw);
    int lat = 1;
    send(d, m);
    while (!ov_u && lat < 10) begin
      @(negedge clk);
      if (!ov_u) lat++;
    end
    // Edges from the acceptance edge to out_valid, counting the acceptance edge.
    check("latency", lat == 2, 32'(lat), 32'd2);
    if (en[0]) begin
      check("dir_dout_u", dout_u == eu, 32'(dout_u), 32'(eu));
      check("dir_sat_u", sat_u == su, 32'(sat_u), 32'(su));
    end
    if (en[1]) begin
      check("dir_dout_s", dout_s == es, 32'(dout_s), 32'(es));
      check("dir_sat_s", sat_s == ss, 32'(sat_s), 32'(ss));
    end
    if (en[2]) begin
      check("dir_dout_w", dout_w == ew, 32'(dout_w), 32'(ew));
      check("dir_sat_w", sat_w == sw, 32'(sat_w), 32'(sw));
    end
    @(posedge clk);
    #1;
  endtask

  // Back-pressure generator.
  initial begin
    out_ready = 1'b1;
    bp_ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_sel)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (bp_ph == 0);
          bp_ph = (bp_ph + 1) % 3;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer and checks handshake rules.
  bit          hold;
  logic [15:0] hd_u, hd_s;
  logic [11:0] hd_w;
  logic [3:0]  hs_u, hs_s;
  logic [1:0]  hs_w;

  always @(negedge clk) begin
    exp_t e;
    bit   emit, acc, exp_rdy;
    if (rst) begin
      occ = 0;
      hold = 1'b0;
      q_u.delete();
      q_s.delete();
      q_w.delete();
`ifdef ROUND_SAT_STATS_EN
      ecnt_u = 0;
      ecnt_s = 0;
      ecnt_w = 0;
`endif
    end else begin
      exp_rdy = !(occ == 2 && !out_ready);
      check("in_ready_u", rdy_u == exp_rdy, 32'(rdy_u), 32'(exp_rdy));
      check("in_ready_s", rdy_s == exp_rdy, 32'(rdy_s), 32'(exp_rdy));
      check("in_ready_w", rdy_w == exp_rdy, 32'(rdy_w), 32'(exp_rdy));
      if (hold) begin
        check("stall_hold_valid", ov_u && ov_s && ov_w, {29'd0, ov_u, ov_s, ov_w}, 32'd7);
        check("stall_hold_u", {dout_u, sat_u} == {hd_u, hs_u}, {dout_u, sat_u}, {hd_u, hs_u});
        check("stall_hold_s", {dout_s, sat_s} == {hd_s, hs_s}, {dout_s, sat_s}, {hd_s, hs_s});
        check("stall_hold_w", {dout_w, sat_w} == {hd_w, hs_w}, {dout_w, sat_w}, {hd_w, hs_w});
      end
`ifdef ROUND_SAT_STATS_EN
      check("sat_count_u", cnt_u == 16'(ecnt_u), 32'(cnt_u), 32'(ecnt_u));
      check("sat_count_s", cnt_s == 16'(ecnt_s), 32'(cnt_s), 32'(ecnt_s));
      check("sat_count_w", cnt_w == 16'(ecnt_w), 32'(cnt_w), 32'(ecnt_w));
`endif
      if (ov_u && out_ready) begin
        if (q_u.size() == 0) check("unexpected_out_u", 1'b0, 32'(dout_u), 32'd0);
        else begin
          e = q_u.pop_front();
          check("dout_u", {dout_u, sat_u} == {e.d, e.s}, {dout_u, sat_u}, {e.d, e.s});
`ifdef ROUND_SAT_STATS_EN
          if (|e.s && ecnt_u < 65535) ecnt_u++;
`endif
        end
      end
      if (ov_s && out_ready) begin
        if (q_s.size() == 0) check("unexpected_out_s", 1'b0, 32'(dout_s), 32'd0);
        else begin
          e = q_s.pop_front();
          check("dout_s", {dout_s, sat_s} == {e.d, e.s}, {dout_s, sat_s}, {e.d, e.s});
`ifdef ROUND_SAT_STATS_EN
          if (|e.s && ecnt_s < 65535) ecnt_s++;
`endif
        end
      end
      if (ov_w && out_ready) begin
        if (q_w.size() == 0) check("unexpected_out_w", 1'b0, 32'(dout_w), 32'd0);
        else begin
          e = q_w.pop_front();
          check("dout_w", {dout_w, sat_w} == {e.d[11:0], e.s[1:0]}, {dout_w, sat_w},
                {e.d[11:0], e.s[1:0]});
`ifdef ROUND_SAT_STATS_EN
          if (|e.s[1:0] && ecnt_w < 65535) ecnt_w++;
`endif
        end
      end
      emit = ov_u && out_ready;
      acc  = in_valid && rdy_u;
      occ  = occ + int'(acc) - int'(emit);
      hold = ov_u && !out_ready;
      hd_u = dout_u; hs_u = sat_u;
      hd_s = dout_s; hs_s = sat_s;
      hd_w = dout_w; hs_w = sat_w;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_mode  = 2'd0;
    din      = '0;
    bp_sel   = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", !ov_u && !ov_s && !ov_w, {29'd0, ov_u, ov_s, ov_w}, 32'd0);
    check("reset_dout", dout_u == 16'd0 && dout_s == 16'd0 && dout_w == 12'd0,
          32'(dout_u), 32'd0);
    check("reset_sat", sat_u == 4'd0 && sat_s == 4'd0 && sat_w == 2'd0, 32'(sat_u), 32'd0);
    @(posedge clk);
    #1;

    direct(32'hF8293828, 2'd2, 3'b011, 16'hF342, 4'b1000, 16'h0342, 4'b0000, 12'h0, 2'b0);
    direct(32'h88888888, 2'd0, 3'b010, 16'h0, 4'b0, 16'h8888, 4'b0000, 12'h0, 2'b0);
    direct(32'h88888888, 2'd1, 3'b010, 16'h0, 4'b0, 16'h9999, 4'b0000, 12'h0, 2'b0);
    direct(32'h88888888, 2'd2, 3'b010, 16'h0, 4'b0, 16'h8888, 4'b0000, 12'h0, 2'b0);
    direct(32'h78787878, 2'd2, 3'b011, 16'h8888, 4'b0000, 16'h7777, 4'b1111, 12'h0, 2'b0);
    direct(32'h000000AA, 2'd3, 3'b100, 16'h0, 4'b0, 16'h0, 4'b0, 12'hEBA, 2'b00);

    // Mid-stream reset with both stages occupied.
    bp_sel = 3;
    @(posedge clk);
    #1;
    send($urandom, 2'd2);
    send($urandom, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", !ov_u && !ov_s && !ov_w, {29'd0, ov_u, ov_s, ov_w}, 32'd0);
    check("rst_in_ready", rdy_u && rdy_s && rdy_w, {29'd0, rdy_u, rdy_s, rdy_w}, 32'd7);
`ifdef ROUND_SAT_STATS_EN
    check("rst_sat_count", cnt_s == 16'd0 && cnt_u == 16'd0, 32'(cnt_s), 32'd0);
`endif
    bp_sel = 0;
    repeat (4) @(posedge clk);
    #1;

    // Fixed 1,0,0 back-pressure over ten back-to-back beats.
    bp_ph  = 0;
    bp_sel = 1;
    for (int i = 0; i < 10; i++) send($urandom, 2'($urandom_range(0, 3)));

    // Random traffic with random back-pressure and gaps; some lanes forced to exact ties.
    bp_sel = 2;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = (d & 32'hF0F0F0F0) | 32'h08080808;
      send(d, 2'($urandom_range(0, 3)));
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end

    bp_sel = 0;
    n = 0;
    while ((q_u.size() + q_s.size() + q_w.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", (q_u.size() + q_s.size() + q_w.size()) == 0,
          32'(q_u.size() + q_s.size() + q_w.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
